// File: rtl/vga_sync_module_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | vga_sync_module_if                                                      |
// | Line prefetch handshake between the raster timer and frame-buffer read. |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface vga_sync_module_if;
    logic       line_req;
    logic [9:0] line_num;
    logic       line_ack;

    modport master (output line_req, output line_num, input line_ack);
    modport slave  (input line_req, input line_num, output line_ack);
endinterface
`default_nettype wire

// File: rtl/vga_sync_module.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | vga_sync_module                                                         |
// | VGA raster timing with registered decodes and one-line-ahead prefetch.  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module vga_sync_module #(
    parameter int H_SYNC   = 128,
    parameter int H_BACK   = 88,
    parameter int H_ACTIVE = 800,
    parameter int H_FRONT  = 40,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 23,
    parameter int V_ACTIVE = 600,
    parameter int V_FRONT  = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              en,
    output logic              HSYNC_Sig,
    output logic              VSYNC_Sig,
    output logic              Ready_Sig,
    output logic [10:0]       Column_Addr_Sig,
    output logic [10:0]       Row_Addr_Sig,
    output logic              frame_start,
    vga_sync_module_if.master line_if,
    output logic              underrun,
    input  logic              underrun_clr
);

    localparam logic [10:0] c_h_total  = 11'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
    localparam logic [10:0] c_h_sync   = 11'(H_SYNC);
    localparam logic [10:0] c_h_ofs    = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] c_h_act_lo = 11'(H_SYNC + H_BACK + 1);
    localparam logic [10:0] c_h_act_hi = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] c_v_total  = 11'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
    localparam logic [10:0] c_v_sync   = 11'(V_SYNC);
    localparam logic [10:0] c_v_act_lo = 11'(V_SYNC + V_BACK + 1);
    localparam logic [10:0] c_v_act_hi = 11'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    logic [10:0] r_h;
    logic [10:0] r_v;
    logic        r_run;
    state_t      r_state;
    logic [9:0]  r_line_num;

    logic [10:0] w_h_nxt;
    logic [10:0] w_v_nxt;
    logic        w_hact;
    logic        w_vact;
    logic [10:0] w_req_line;
    logic        w_req_act;
    state_t      w_state_nxt;
    logic [9:0]  w_num_nxt;
    logic        w_miss;

    // A stopped or freshly-enabled raster always (re)starts at (1,1).
    always_comb begin
        w_h_nxt = 11'd1;
        w_v_nxt = 11'd1;
        if (en && r_run) begin
            if (r_h == c_h_total) begin
                w_v_nxt = (r_v == c_v_total) ? 11'd1 : r_v + 11'd1;
            end else begin
                w_h_nxt = r_h + 11'd1;
                w_v_nxt = r_v;
            end
        end
    end

    assign w_hact     = (w_h_nxt >= c_h_act_lo) && (w_h_nxt <= c_h_act_hi);
    assign w_vact     = (w_v_nxt >= c_v_act_lo) && (w_v_nxt <= c_v_act_hi);
    assign w_req_line = (w_v_nxt == c_v_total) ? 11'd1 : w_v_nxt + 11'd1;
    assign w_req_act  = (w_req_line >= c_v_act_lo) && (w_req_line <= c_v_act_hi);

    // Retire on ack or deadline first; a new line start may then re-arm.
    always_comb begin
        w_state_nxt = r_state;
        w_num_nxt   = r_line_num;
        w_miss      = 1'b0;
        if (r_state == ST_PEND) begin
            if (line_if.line_ack) begin
                w_state_nxt = ST_IDLE;
            end else if (r_h == c_h_total) begin
                w_state_nxt = ST_IDLE;
                w_miss      = 1'b1;
            end
        end
        if ((w_h_nxt == 11'd1) && w_req_act) begin
            w_state_nxt = ST_PEND;
            w_num_nxt   = 10'(w_req_line - c_v_act_lo);
        end
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_num_nxt   = 10'd0;
            w_miss      = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= ST_IDLE;
            r_line_num <= 10'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_line_num <= w_num_nxt;
        end
    end

    assign line_if.line_req = (r_state == ST_PEND);
    assign line_if.line_num = r_line_num;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_h             <= 11'd1;
            r_v             <= 11'd1;
            r_run           <= 1'b0;
            HSYNC_Sig       <= 1'b1;
            VSYNC_Sig       <= 1'b1;
            Ready_Sig       <= 1'b0;
            Column_Addr_Sig <= 11'd0;
            Row_Addr_Sig    <= 11'd0;
            frame_start     <= 1'b0;
        end else if (!en) begin
            r_h             <= 11'd1;
            r_v             <= 11'd1;
            r_run           <= 1'b0;
            HSYNC_Sig       <= 1'b1;
            VSYNC_Sig       <= 1'b1;
            Ready_Sig       <= 1'b0;
            Column_Addr_Sig <= 11'd0;
            Row_Addr_Sig    <= 11'd0;
            frame_start     <= 1'b0;
        end else begin
            r_h             <= w_h_nxt;
            r_v             <= w_v_nxt;
            r_run           <= 1'b1;
            HSYNC_Sig       <= (w_h_nxt > c_h_sync);
            VSYNC_Sig       <= (w_v_nxt > c_v_sync);
            Ready_Sig       <= w_hact && w_vact;
            Column_Addr_Sig <= w_hact ? (w_h_nxt - c_h_ofs) : 11'd0;
            Row_Addr_Sig    <= w_v_nxt;
            frame_start     <= (w_h_nxt == 11'd1) && (w_v_nxt == 11'd1);
        end
    end

    // A miss in the same cycle as a clear leaves the flag set.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            underrun <= 1'b0;
        end else if (w_miss) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_module.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_vga_sync_module                                                      |
// | Scoreboard bench on a shrunken raster (17 x 10) for vga_sync_module.    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_vga_sync_module;

    localparam int HS_W = 4, HB_W = 3, HA_W = 8, HF_W = 2;
    localparam int VS_W = 2, VB_W = 2, VA_W = 5, VF_W = 1;
    localparam int HT = HS_W + HB_W + HA_W + HF_W;
    localparam int VT = VS_W + VB_W + VA_W + VF_W;
    localparam logic [37:0] RST_VEC = {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 10'd0, 1'b0};

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        en = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        HSYNC_Sig, VSYNC_Sig, Ready_Sig, frame_start, underrun;
    logic [10:0] Column_Addr_Sig, Row_Addr_Sig;

    vga_sync_module_if u_if();

    vga_sync_module #(
        .H_SYNC(HS_W), .H_BACK(HB_W), .H_ACTIVE(HA_W), .H_FRONT(HF_W),
        .V_SYNC(VS_W), .V_BACK(VB_W), .V_ACTIVE(VA_W), .V_FRONT(VF_W)
    ) u_dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .en              (en),
        .HSYNC_Sig       (HSYNC_Sig),
        .VSYNC_Sig       (VSYNC_Sig),
        .Ready_Sig       (Ready_Sig),
        .Column_Addr_Sig (Column_Addr_Sig),
        .Row_Addr_Sig    (Row_Addr_Sig),
        .frame_start     (frame_start),
        .line_if         (u_if),
        .underrun        (underrun),
        .underrun_clr    (underrun_clr)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference raster state: position, prefetch and sticky flag
    int  mh = 1, mv = 1, mnum = 0, mage = 0;
    bit  mrun = 0, mpend = 0, mund = 0;
    int  ack_mode = 0;
    bit  noack_en = 0;
    bit  count_en = 0;
    int  cyc = 0, fs_last = -1, fs_cnt = 0, hs_low = 0, vs_low = 0;
    logic [37:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [37:0] dut_vec();
        return {HSYNC_Sig, VSYNC_Sig, Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, frame_start,
                u_if.line_req, (u_if.line_req ? u_if.line_num : 10'd0), underrun};
    endfunction

    function automatic logic [37:0] model_vec();
        logic hact, vact;
        if (!mrun) return {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 10'd0, mund};
        hact = (mh > HS_W + HB_W) && (mh <= HS_W + HB_W + HA_W);
        vact = (mv > VS_W + VB_W) && (mv <= VS_W + VB_W + VA_W);
        return {(mh > HS_W), (mv > VS_W), hact && vact,
                (hact ? 11'(mh - HS_W - HB_W) : 11'd0), 11'(mv),
                (mh == 1 && mv == 1), mpend, (mpend ? 10'(mnum) : 10'd0), mund};
    endfunction

    task automatic model_step(input logic ack);
        bit miss;
        int nl;
        miss = 0;
        if (!RSTn) begin
            mrun = 0; mh = 1; mv = 1; mpend = 0; mund = 0;
        end else begin
            if (!en) begin
                mrun = 0; mh = 1; mv = 1; mpend = 0;
            end else begin
                if (mpend) begin
                    if (ack) mpend = 0;
                    else if (mh == HT) begin mpend = 0; miss = 1; end
                end
                if (mpend) mage++;
                if (!mrun) begin mrun = 1; mh = 1; mv = 1; end
                else if (mh == HT) begin mh = 1; mv = (mv == VT) ? 1 : mv + 1; end
                else mh++;
                nl = (mv == VT) ? 1 : mv + 1;
                if (mh == 1 && nl > VS_W + VB_W && nl <= VS_W + VB_W + VA_W) begin
                    mpend = 1; mnum = nl - VS_W - VB_W - 1; mage = 0;
                end
            end
            if (miss) mund = 1;
            else if (underrun_clr) mund = 0;
        end
    endtask

    task automatic tick();
        logic ack;
        logic [37:0] e;
        case (ack_mode)
            0:       ack = mpend && (mage == 5) && !(noack_en && mv == 6);
            1:       ack = mpend && (mh == HT);
            2:       ack = mpend ? (mage == 5) : 1'($urandom_range(0, 1));
            default: ack = 1'b0;
        endcase
        u_if.line_ack = ack;
        model_step(ack);
        exp_q.push_back(model_vec());
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check_val("raster", 64'(dut_vec()), 64'(e));
        if (mrun) begin
            if (mh == 8 && mv == 5)  check_val("act_first", 64'({Ready_Sig, Column_Addr_Sig}), 64'({1'b1, 11'd1}));
            if (mh == 15 && mv == 5) check_val("act_last", 64'({Ready_Sig, Column_Addr_Sig}), 64'({1'b1, 11'd8}));
            if (mh == 16 && mv == 5) check_val("act_end", 64'({Ready_Sig, Column_Addr_Sig}), 64'({1'b0, 11'd0}));
            if (mh == 10 && mv == 10) check_val("last_line", 64'(Ready_Sig), 64'(0));
            if (mh == 1 && mv == 4)  check_val("req_first", 64'({u_if.line_req, u_if.line_num}), 64'({1'b1, 10'd0}));
            if (mh == 1 && mv == 8)  check_val("req_last", 64'({u_if.line_req, u_if.line_num}), 64'({1'b1, 10'd4}));
            if (mh == 1 && mv >= 9)  check_val("req_none", 64'(u_if.line_req), 64'(0));
            if (noack_en && mh == HT && mv == 6)
                check_val("miss_hold", 64'({u_if.line_req, underrun}), 64'({1'b1, 1'b0}));
            if (noack_en && mh == 1 && mv == 7)
                check_val("miss_next", 64'({u_if.line_req, u_if.line_num, underrun}), 64'({1'b1, 10'd3, 1'b1}));
        end
        if (count_en) begin
            if (!HSYNC_Sig) hs_low++;
            if (!VSYNC_Sig) vs_low++;
            if (frame_start) begin
                if (fs_last >= 0) check_val("fs_period", 64'(cyc - fs_last), 64'(HT * VT));
                fs_last = cyc;
                fs_cnt++;
            end
        end
        cyc++;
    endtask

    initial begin
        u_if.line_ack = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_val("reset", 64'({dut_vec(), u_if.line_num}), 64'({RST_VEC, 10'd0}));

        // Two full frames with ack five cycles after each request
        RSTn = 1'b1; en = 1'b1; count_en = 1;
        repeat (2 * HT * VT) tick();
        count_en = 0;
        check_val("hs_low", 64'(hs_low), 64'(2 * VT * HS_W));
        check_val("vs_low", 64'(vs_low), 64'(2 * VS_W * HT));
        check_val("fs_count", 64'(fs_cnt), 64'(2));
        check_val("und_none", 64'(underrun), 64'(0));

        // Line 6 left unacknowledged
        noack_en = 1;
        repeat (HT * VT) tick();
        noack_en = 0;
        repeat (5) tick();
        check_val("und_sticky", 64'(underrun), 64'(1));
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check_val("und_clr", 64'(underrun), 64'(0));

        ack_mode = 1;
        repeat (HT * VT) tick();
        check_val("und_deadline", 64'(underrun), 64'(0));

        ack_mode = 2;
        repeat (HT * VT) tick();
        check_val("und_spurious", 64'(underrun), 64'(0));

        // Drop en while a request is pending
        ack_mode = 0; noack_en = 1;
        for (int i = 0; i < 4 * HT * VT && !(mh == 10 && mv == 6); i++) tick();
        check_val("reach_pos", 64'(mv * 100 + mh), 64'(610));
        check_val("pend_before_off", 64'({u_if.line_req, u_if.line_num}), 64'({1'b1, 10'd2}));
        en = 1'b0; noack_en = 0;
        repeat (10) begin
            tick();
            check_val("en_off", 64'({dut_vec(), u_if.line_num}), 64'({RST_VEC, 10'd0}));
        end
        en = 1'b1;
        tick();
        check_val("restart", 64'({frame_start, Row_Addr_Sig, Column_Addr_Sig, HSYNC_Sig}),
                  64'({1'b1, 11'd1, 11'd0, 1'b0}));

        // Asynchronous reset mid-line
        repeat (20) tick();
        #3 RSTn = 1'b0;
        #1;
        check_val("async_rst", 64'({dut_vec(), u_if.line_num}), 64'({RST_VEC, 10'd0}));
        repeat (2) tick();
        RSTn = 1'b1;
        repeat (30) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
